shift_req_arbiter: RTL and testbench

//   Shares one logical shifter datapath (param_left_shifter + param_right_shifter,

---
 rtl/shift_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_shift_req_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin front end for a shared logical shifter pair.
// Operands are registered on accept; the shifted result is registered and held until taken.

module param_left_shifter #(
  parameter int N         = 32,
  parameter int AMT_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         i_a,
  input  logic [AMT_WIDTH-1:0] i_amt,
  output logic [N-1:0]         o_y
);

  logic [N-1:0] w_stage [AMT_WIDTH+1];

  assign w_stage[0] = i_a;

  // Log-depth barrel: stage s shifts by 2**s when amount bit s is set.
  for (genvar s = 0; s < AMT_WIDTH; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign w_stage[s+1] = i_amt[s] ? {w_stage[s][N-1-SH:0], {SH{1'b0}}} : w_stage[s];
  end

  assign o_y = w_stage[AMT_WIDTH];

endmodule

module param_right_shifter #(
  parameter int N         = 32,
  parameter int AMT_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         i_a,
  input  logic [AMT_WIDTH-1:0] i_amt,
  output logic [N-1:0]         o_y
);

  logic [N-1:0] w_stage [AMT_WIDTH+1];

  assign w_stage[0] = i_a;

  for (genvar s = 0; s < AMT_WIDTH; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign w_stage[s+1] = i_amt[s] ? {{SH{1'b0}}, w_stage[s][N-1:SH]} : w_stage[s];
  end

  assign o_y = w_stage[AMT_WIDTH];

endmodule

module shift_req_arbiter #(
  parameter  int N         = 32,
  localparam int AMT_WIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [N-1:0]         r0_a,
  input  logic [AMT_WIDTH-1:0] r0_amt,
  input  logic                 r0_dir,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [N-1:0]         r1_a,
  input  logic [AMT_WIDTH-1:0] r1_amt,
  input  logic                 r1_dir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_last_grant;
  logic [N-1:0]         r_a;
  logic [AMT_WIDTH-1:0] r_amt;
  logic                 r_dir;
  logic [N-1:0]         r_out_data;
  logic                 r_out_id;
  logic                 r_out_valid;

  logic                 w_grant_id;
  logic                 w_accept;
  logic [N-1:0]         w_left_y;
  logic [N-1:0]         w_right_y;

  // Tie goes to whoever did not win last; a lone requester always wins.
  assign w_grant_id = (r0_valid & r1_valid) ? ~r_last_grant : r1_valid;
  assign w_accept   = (r_state == S_IDLE) & (r0_valid | r1_valid);

  // Gating with rst_n keeps every output low for the whole reset window.
  assign r0_ready = w_accept & ~w_grant_id & rst_n;
  assign r1_ready = w_accept &  w_grant_id & rst_n;

  param_left_shifter #(.N(N), .AMT_WIDTH(AMT_WIDTH)) u_left (
    .i_a   (r_a),
    .i_amt (r_amt),
    .o_y   (w_left_y)
  );

  param_right_shifter #(.N(N), .AMT_WIDTH(AMT_WIDTH)) u_right (
    .i_a   (r_a),
    .i_amt (r_amt),
    .o_y   (w_right_y)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_amt        <= '0;
      r_dir        <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant_id ? r1_a   : r0_a;
        r_amt        <= w_grant_id ? r1_amt : r0_amt;
        r_dir        <= w_grant_id ? r1_dir : r0_dir;
        r_last_grant <= w_grant_id;
      end
      // r_last_grant doubles as the in-flight requester id.
      if (r_state == S_SHIFT) begin
        r_out_data  <= r_dir ? w_right_y : w_left_y;
        r_out_id    <= r_last_grant;
        r_out_valid <= 1'b1;
      end
      if ((r_state == S_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed and randomized checks of shift_req_arbiter against a transaction-level
// model: round-robin winner from the request pattern, result by repeated *2 or /2.

module tb_shift_req_arbiter;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [N-1:0]  r0_a, r1_a;
  logic [AW-1:0] r0_amt, r1_amt;
  logic          r0_dir, r1_dir;
  logic          out_valid, out_ready, out_id, busy;
  logic [N-1:0]  out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_last;

  shift_req_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_amt    (r0_amt),
    .r0_dir    (r0_dir),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_amt    (r1_amt),
    .r1_dir    (r1_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt, input bit dir);
    longint unsigned v = 64'(a);
    for (int i = 0; i < amt; i++) v = dir ? v / 2 : (v * 2) % 64'h1_0000_0000;
    return v[31:0];
  endfunction

  function automatic bit ref_grant(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  task automatic rand_inputs(input bit keep_valid);
    if (!keep_valid) begin
      r0_valid = 1'($urandom);
      r1_valid = 1'($urandom);
    end
    r0_a = $urandom; r0_amt = 5'($urandom); r0_dir = 1'($urandom);
    r1_a = $urandom; r1_amt = 5'($urandom); r1_dir = 1'($urandom);
  endtask

  // Entered 1 time unit after a rising edge with the DUT idle.
  task automatic run_op(input bit v0, input logic [31:0] a0, input int m0, input bit d0,
                        input bit v1, input logic [31:0] a1, input int m1, input bit d1,
                        input int hold, input bit keep_valid, input string tag,
                        output int acc_cyc, output bit granted);
    bit g;
    logic [31:0] exp;
    r0_valid = v0; r0_a = a0; r0_amt = 5'(m0); r0_dir = d0;
    r1_valid = v1; r1_a = a1; r1_amt = 5'(m1); r1_dir = d1;
    out_ready = 1'b0;
    #1;
    g   = ref_grant(v0, v1, model_last);
    exp = g ? ref_shift(a1, m1, d1) : ref_shift(a0, m0, d0);
    check({tag, " r0_ready"}, 32'(r0_ready), 32'(!g));
    check({tag, " r1_ready"}, 32'(r1_ready), 32'(g));
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    acc_cyc    = cyc;
    granted    = g;
    model_last = g;
    #1;
    rand_inputs(keep_valid);
    #1;
    check({tag, " shift busy"}, 32'(busy), 32'd1);
    check({tag, " shift readies"}, 32'({r0_ready, r1_ready}), 32'd0);
    check({tag, " shift out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_data"}, out_data, exp);
    check({tag, " out_id"}, 32'(out_id), 32'(g));
    for (int i = 0; i < hold; i++) begin
      rand_inputs(keep_valid);
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold out_data"}, out_data, exp);
      check({tag, " hold out_id"}, 32'(out_id), 32'(g));
      check({tag, " hold readies"}, 32'({r0_ready, r1_ready}), 32'd0);
      check({tag, " hold busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " done out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " done busy"}, 32'(busy), 32'd0);
    check({tag, " kept out_data"}, out_data, exp);
  endtask

  initial begin
    int  acc, prev_acc;
    bit  g;
    bit  v0, v1;

    // Reset with both requests asserted: every output must still be low.
    rst_n = 1'b0; out_ready = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = '0; r0_amt = '0; r0_dir = 1'b0;
    r1_a = '0; r1_amt = '0; r1_dir = 1'b0;
    model_last = 1'b1;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_id", 32'(out_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset readies", 32'({r0_ready, r1_ready}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both held valid: grants alternate 0,1,0,1 with accepts 3 cycles apart.
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      run_op(1'b1, 32'h0000_0F0F + 32'(k), k + 1, 1'b0,
             1'b1, 32'hF0F0_0000 - 32'(k), k + 2, 1'b1,
             0, 1'b1, $sformatf("tie%0d", k), acc, g);
      check($sformatf("tie%0d grant", k), 32'(g), 32'(k % 2));
      if (k > 0) check($sformatf("tie%0d spacing", k), 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Directed vectors, including amt=0 and the amt=N-1 extremes.
    run_op(1'b1, 32'h0000_001A, 3, 1'b0, 1'b0, '0, 0, 1'b0, 0, 1'b0, "r0_left3", acc, g);
    run_op(1'b0, '0, 0, 1'b0, 1'b1, 32'h0000_001A, 1, 1'b1, 0, 1'b0, "r1_right1", acc, g);
    run_op(1'b0, '0, 0, 1'b0, 1'b1, 32'h0000_001A, 0, 1'b1, 0, 1'b0, "r1_amt0", acc, g);
    run_op(1'b1, 32'h8000_0000, 31, 1'b1, 1'b0, '0, 0, 1'b0, 0, 1'b0, "right31", acc, g);
    run_op(1'b0, '0, 0, 1'b0, 1'b1, 32'h0000_0001, 31, 1'b0, 0, 1'b0, "left31", acc, g);

    // Consumer stalls for 5 cycles while both requesters keep asking.
    run_op(1'b1, 32'hDEAD_BEEF, 4, 1'b1, 1'b1, 32'h1234_5678, 8, 1'b0, 5, 1'b1, "stall5", acc, g);

    // Idle with no requests: nothing is granted, nothing appears.
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("noreq readies", 32'({r0_ready, r1_ready}), 32'd0);
      check("noreq busy", 32'(busy), 32'd0);
      check("noreq out_valid", 32'(out_valid), 32'd0);
    end

    for (int k = 0; k < 24; k++) begin
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      run_op(v0, $urandom, int'($urandom_range(0, 31)), 1'($urandom),
             v1, $urandom, int'($urandom_range(0, 31)), 1'($urandom),
             int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd%0d", k), acc, g);
    end

    // Leave a nonzero result visible, then reset in the middle of the next op.
    run_op(1'b1, 32'h0000_00FF, 4, 1'b0, 1'b0, '0, 0, 1'b0, 0, 1'b0, "pre_rst", acc, g);
    r0_valid = 1'b1; r0_a = 32'hCAFE_F00D; r0_amt = 5'd2; r0_dir = 1'b0;
    r1_valid = 1'b1; r1_a = 32'h0BAD_F00D; r1_amt = 5'd3; r1_dir = 1'b1;
    @(posedge clk); #1;
    check("pre-abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", out_data, 32'd0);
    check("abort out_id", 32'(out_id), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort readies", 32'({r0_ready, r1_ready}), 32'd0);
    model_last = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post-abort out_valid", 32'(out_valid), 32'd0);
      check("post-abort busy", 32'(busy), 32'd0);
    end
    run_op(1'b1, 32'h0000_0003, 5, 1'b0, 1'b1, 32'h0000_0300, 5, 1'b1, 0, 1'b0, "post_rst_tie", acc, g);
    check("post_rst_tie grant", 32'(g), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
